// File: rtl/mpsoc_spram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpsoc_spram_pkg
//  Brief    : Shared types and helpers for the single-port RAM array:
//             INIT/READY state encoding and address-slicing width helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package mpsoc_spram_pkg;

    // Two-state controller: clear every word after reset, then serve requests.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } spram_state_e;

    // Number of byte-offset address bits below the word index.
    function automatic int log_nr_bytes(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Number of address bits needed to select one word.
    function automatic int idx_width(input int mem_depth);
        return $clog2(mem_depth);
    endfunction

endpackage : mpsoc_spram_pkg
`default_nettype wire

// File: rtl/mpsoc_spram_parity.sv
`default_nettype none
// ============================================================================
//  Module   : mpsoc_spram_parity
//  Brief    : Combinational per-byte even-parity generation for write data
//             and per-byte parity checking for read data.
//  Revision : 1.0 - initial release
// ============================================================================
module mpsoc_spram_parity #(
    parameter int NR_BYTES = 8
) (
    input  logic [NR_BYTES*8-1:0] i_wr_data,
    output logic [NR_BYTES-1:0]   o_wr_par,
    input  logic [NR_BYTES*8-1:0] i_rd_data,
    input  logic [NR_BYTES-1:0]   i_rd_par,
    output logic [NR_BYTES-1:0]   o_rd_err
);

    // Parity bit makes byte + bit carry an even number of ones; a lane errs
    // when the stored bit no longer matches the byte it was stored with.
    always_comb begin
        o_wr_par = '0;
        o_rd_err = '0;
        for (int b = 0; b < NR_BYTES; b++) begin
            o_wr_par[b] = ^i_wr_data[b*8 +: 8];
            o_rd_err[b] = i_rd_par[b] ^ (^i_rd_data[b*8 +: 8]);
        end
    end

endmodule : mpsoc_spram_parity
`default_nettype wire

// File: rtl/mpsoc_spram_array.sv
`default_nettype none
// ============================================================================
//  Module   : mpsoc_spram_array
//  Brief    : Single-port word RAM with byte enables, self-clearing after
//             reset, 1-cycle registered read. Optional per-byte parity with
//             error injection, enabled by defining MPSOC_SPRAM_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mpsoc_spram_array
    import mpsoc_spram_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   data_i,
    output logic [AXI_DATA_WIDTH-1:0]   data_o,
    input  logic                        inj_i,
    output logic                        init_done_o,
    output logic [AXI_DATA_WIDTH/8-1:0] par_err_o,
    output logic [15:0]                 err_cnt_o
);

    localparam int c_NR_BYTES     = AXI_DATA_WIDTH / 8;
    localparam int c_LOG_NR_BYTES = log_nr_bytes(AXI_DATA_WIDTH);
    localparam int c_IDX_W        = idx_width(MEM_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(MEM_DEPTH - 1);

    spram_state_e              r_state;
    logic [c_IDX_W-1:0]        r_cnt;
    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [c_IDX_W-1:0]        w_idx;
    logic                      w_rd;
    logic                      w_wr;
    logic                      w_unused;

    // Upper address bits alias onto the array and byte-offset bits are
    // ignored; only the index slice is decoded.
    assign w_idx    = addr_i[c_LOG_NR_BYTES +: c_IDX_W];
    assign w_unused = ^{inj_i, addr_i};

    assign w_rd = !rst_i && (r_state == ST_READY) && req_i && !we_i;
    assign w_wr = !rst_i && (r_state == ST_READY) && req_i &&  we_i;

    assign init_done_o = (r_state == ST_READY);
    assign data_o      = r_data;

    // Controller: sweep every index once after reset, then stay READY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            if (r_cnt == c_LAST_IDX) begin
                r_state <= ST_READY;
            end
            r_cnt <= r_cnt + c_IDX_W'(1);
        end
    end

    // Data array: zero fill during INIT, byte-masked writes once READY.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (r_state == ST_INIT)) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < c_NR_BYTES; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register: loads only on a read, otherwise holds (no write-through).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
        end else if (w_rd) begin
            r_data <= r_mem[w_idx];
        end
    end

`ifdef MPSOC_SPRAM_PARITY_EN
    logic [c_NR_BYTES-1:0] r_par_mem [MEM_DEPTH];
    logic [c_NR_BYTES-1:0] w_wr_par;
    logic [c_NR_BYTES-1:0] w_rd_err;
    logic [c_NR_BYTES-1:0] r_par_err;
    logic [15:0]           r_err_cnt;

    mpsoc_spram_parity #(
        .NR_BYTES (c_NR_BYTES)
    ) u_parity (
        .i_wr_data (data_i),
        .o_wr_par  (w_wr_par),
        .i_rd_data (r_mem[w_idx]),
        .i_rd_par  (r_par_mem[w_idx]),
        .o_rd_err  (w_rd_err)
    );

    // Parity array: zero parity for zero words during INIT; injection flips
    // the stored bit of every lane written this cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (r_state == ST_INIT)) begin
            r_par_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < c_NR_BYTES; b++) begin
                if (be_i[b]) begin
                    r_par_mem[w_idx][b] <= w_wr_par[b] ^ inj_i;
                end
            end
        end
    end

    // Error flags are registered alongside the read data; the counter moves
    // in the same cycle the flags appear and sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_par_err <= '0;
            r_err_cnt <= '0;
        end else begin
            r_par_err <= w_rd ? w_rd_err : '0;
            if (w_rd && (|w_rd_err) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign par_err_o = r_par_err;
    assign err_cnt_o = r_err_cnt;
`else
    assign par_err_o = '0;
    assign err_cnt_o = '0;
`endif

endmodule : mpsoc_spram_array
`default_nettype wire

// File: tb/tb_mpsoc_spram_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpsoc_spram_array
//  Brief    : Self-checking bench for mpsoc_spram_array against a word-array
//             reference model (data, per-lane bad-parity flags, error count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mpsoc_spram_array;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int NB    = DW / 8;
`ifdef MPSOC_SPRAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [NB-1:0] be_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          inj_i;
    logic          init_done_o;
    logic [NB-1:0] par_err_o;
    logic [15:0]   err_cnt_o;

    mpsoc_spram_array #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .MEM_DEPTH      (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .inj_i       (inj_i),
        .init_done_o (init_done_o),
        .par_err_o   (par_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents, lanes holding bad parity, expected outputs.
    logic [DW-1:0] m_mem [DEPTH];
    logic [NB-1:0] m_bad [DEPTH];
    logic [DW-1:0] e_data;
    logic [NB-1:0] e_par;
    logic [15:0]   e_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = '0;
        end
        e_data = '0;
        e_par  = '0;
        e_cnt  = '0;
    endtask

    // Count edges from reset release until init_done_o rises.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!init_done_o && n < 4 * DEPTH);
        check(tag, 64'(n), 64'(DEPTH));
    endtask

    // One READY-mode cycle: drive, advance the model, then check outputs.
    task automatic cycle(input logic req, input logic we, input logic [63:0] addr,
                         input logic [NB-1:0] be, input logic [DW-1:0] data,
                         input logic inj, input string tag);
        int idx;
        req_i  = req;
        we_i   = we;
        addr_i = addr;
        be_i   = be;
        data_i = data;
        inj_i  = inj;
        idx    = int'((addr / 8) % DEPTH);
        if (req && !we) begin
            e_data = m_mem[idx];
            e_par  = PAR_EN ? m_bad[idx] : '0;
            if (e_par != 0 && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end else begin
            e_par = '0;
        end
        if (req && we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    m_mem[idx][b*8 +: 8] = data[b*8 +: 8];
                    m_bad[idx][b]        = inj;
                end
            end
        end
        step();
        check({tag, ".data"}, data_o, e_data);
        check({tag, ".par"}, 64'(par_err_o), 64'(e_par));
        check({tag, ".cnt"}, 64'(err_cnt_o), 64'(e_cnt));
        check({tag, ".rdy"}, 64'(init_done_o), 64'd1);
        req_i = 1'b0;
        we_i  = 1'b0;
        inj_i = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;

        // Reset with a write request held through reset and INIT.
        rst_i  = 1'b1;
        req_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = 64'h0;
        be_i   = '1;
        data_i = '1;
        inj_i  = 1'b1;
        model_clear();
        step();
        step();
        check("rst.init_done", 64'(init_done_o), 64'd0);
        check("rst.data", data_o, 64'd0);
        check("rst.par", 64'(par_err_o), 64'd0);
        check("rst.cnt", 64'(err_cnt_o), 64'd0);

        rst_i = 1'b0;
        wait_init("init.cycles");
        req_i = 1'b0;
        we_i  = 1'b0;
        inj_i = 1'b0;
        check("init.data_held", data_o, 64'd0);

        // Fresh memory reads zero, including the word targeted during INIT.
        cycle(1, 0, 64'h28, '0, '0, 0, "rd5");
        check("rd5.zero", data_o, 64'd0);
        cycle(1, 0, 64'h0, '0, '0, 0, "rd0_ignored_init_wr");

        // Byte-lane merge.
        cycle(1, 1, 64'h40, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, "be.wr1");
        cycle(1, 1, 64'h40, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, "be.wr2");
        cycle(1, 1, 64'h40, 8'h00, 64'h5555_5555_5555_5555, 0, "be.noop");
        cycle(1, 0, 64'h40, '0, '0, 0, "be.rd");
        check("be.literal", data_o, 64'h0123_4567_FFFF_FFFF);

        // Back-to-back reads, then hold across idle and write cycles.
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 64'(i * 8), '1, {$urandom, $urandom}, 0, "b2b.wr");
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 64'(i * 8), '0, '0, 0, "b2b.rd");
        end
        cycle(0, 0, 64'h0, '0, '0, 0, "hold.idle");
        cycle(1, 1, 64'h78, '1, 64'hDEAD_BEEF_CAFE_F00D, 0, "hold.wr");

        // Aliasing: upper address bits are ignored.
        d = {$urandom, $urandom};
        cycle(1, 1, 64'h2008, '1, d, 0, "alias.wr");
        cycle(1, 0, 64'h0008, '0, '0, 0, "alias.rd");
        check("alias.literal", data_o, d);

        // Parity injection on two lanes, then repair.
        cycle(1, 1, 64'h10, 8'h03, {$urandom, $urandom}, 1, "par.inj_wr");
        cycle(1, 0, 64'h10, '0, '0, 0, "par.rd_bad");
        check("par.flags", 64'(par_err_o), PAR_EN ? 64'h03 : 64'h00);
        check("par.count", 64'(err_cnt_o), PAR_EN ? 64'd1 : 64'd0);
        cycle(0, 0, 64'h0, '0, '0, 0, "par.idle");
        cycle(1, 1, 64'h10, 8'h03, {$urandom, $urandom}, 0, "par.fix_wr");
        cycle(1, 0, 64'h10, '0, '0, 0, "par.rd_ok");
        check("par.clean", 64'(par_err_o), 64'd0);

        // Random traffic over a small window with random aliasing/offsets.
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            a[12:3] = 10'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                  NB'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0), "rand");
        end

        // Reset during READY with a read in flight.
        d = {$urandom, $urandom} | 64'h1;
        cycle(1, 1, 64'h100, '1, d, 0, "rst2.wr");
        rst_i  = 1'b1;
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 64'h100;
        step();
        check("rst2.init_done", 64'(init_done_o), 64'd0);
        check("rst2.data_discard", data_o, 64'd0);
        check("rst2.cnt", 64'(err_cnt_o), 64'd0);
        rst_i = 1'b0;
        req_i = 1'b0;
        model_clear();
        wait_init("rst2.init_cycles");
        cycle(1, 0, 64'h100, '0, '0, 0, "rst2.rd");
        check("rst2.cleared", data_o, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mpsoc_spram_array
`default_nettype wire
